// File: rtl/nand_cmd_sequencer.sv
// NAND command/address sequencer: issues CMD1, up to five address bytes and an
// optional CMD2 through the command/address latch units, handshaking on busy.
module nand_cmd_sequencer #(
    parameter int unsigned BUSY_TIMEOUT = 4,
    parameter int unsigned T_WB_CYCLES  = 0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [7:0]  cmd1,
    input  logic [2:0]  addr_count,
    input  logic [39:0] addr,
    input  logic        has_cmd2,
    input  logic [7:0]  cmd2,
    input  logic        cle_busy,
    input  logic        ale_busy,
    output logic        cle_activate,
    output logic        ale_activate,
    output logic [15:0] latch_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned WAIT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int unsigned TWB_W  = (T_WB_CYCLES > 1) ? $clog2(T_WB_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
    localparam logic [TWB_W-1:0]  TWB_LAST  = TWB_W'((T_WB_CYCLES > 0) ? T_WB_CYCLES - 1 : 0);
    localparam logic [2:0]        MAX_ADDR  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD1,
        S_CMD1_WAIT,
        S_ADDR,
        S_ADDR_WAIT,
        S_CMD2,
        S_CMD2_WAIT,
        S_TWB,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cmd1_q, cmd1_d;
    logic [7:0]         cmd2_q, cmd2_d;
    logic [39:0]        addr_q, addr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               has_cmd2_q, has_cmd2_d;
    logic [2:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               seen_q, seen_d;
    logic [TWB_W-1:0]   twb_cnt_q, twb_cnt_d;
    logic               cle_activate_q, cle_activate_d;
    logic               ale_activate_q, ale_activate_d;
    logic [15:0]        latch_data_q, latch_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               in_wait;
    logic               wait_busy;
    logic               wait_exit;
    logic               timeout;

    // Next-state, capture, busy handshake and registered-output computation
    always_comb begin
        state_d        = state_q;
        cmd1_d         = cmd1_q;
        cmd2_d         = cmd2_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        has_cmd2_d     = has_cmd2_q;
        idx_d          = idx_q;
        wait_cnt_d     = wait_cnt_q;
        seen_d         = seen_q;
        twb_cnt_d      = twb_cnt_q;
        cle_activate_d = 1'b0;
        ale_activate_d = 1'b0;
        latch_data_d   = 16'h0000;
        busy_d         = 1'b0;
        done_d         = 1'b0;
        error_d        = 1'b0;
        wait_exit      = 1'b0;
        timeout        = 1'b0;

        in_wait   = (state_q == S_CMD1_WAIT) || (state_q == S_ADDR_WAIT) ||
                    (state_q == S_CMD2_WAIT);
        // Only the addressed latch unit's busy matters in a WAIT state
        wait_busy = (state_q == S_ADDR_WAIT) ? ale_busy : cle_busy;

        // Busy must rise (within the timeout window) and then fall
        if (in_wait) begin
            if (!seen_q) begin
                if (wait_busy) begin
                    seen_d = 1'b1;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end else if (!wait_busy) begin
                wait_exit = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped
                if (start && !done_q) begin
                    cmd1_d     = cmd1;
                    cmd2_d     = cmd2;
                    addr_d     = addr;
                    cnt_d      = (addr_count > MAX_ADDR) ? MAX_ADDR : addr_count;
                    has_cmd2_d = has_cmd2;
                    idx_d      = 3'd0;
                    state_d    = S_CMD1;
                end
            end
            S_CMD1: state_d = S_CMD1_WAIT;
            S_CMD1_WAIT: begin
                if (wait_exit) begin
                    if (cnt_q != 3'd0) begin
                        state_d = S_ADDR;
                    end else if (has_cmd2_q) begin
                        state_d = S_CMD2;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_ADDR: state_d = S_ADDR_WAIT;
            S_ADDR_WAIT: begin
                if (wait_exit) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_d < cnt_q) begin
                        state_d = S_ADDR;
                    end else if (has_cmd2_q) begin
                        state_d = S_CMD2;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_CMD2: state_d = S_CMD2_WAIT;
            S_CMD2_WAIT: begin
                if (wait_exit) begin
                    twb_cnt_d = '0;
                    state_d   = (T_WB_CYCLES == 0) ? S_FINISH : S_TWB;
                end
            end
            S_TWB: begin
                if (twb_cnt_q == TWB_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    twb_cnt_d = twb_cnt_q + TWB_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout aborts the sequence straight back to IDLE
        if (timeout) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end

        // Fresh handshake tracking for every activate
        if ((state_d == S_CMD1) || (state_d == S_ADDR) || (state_d == S_CMD2)) begin
            wait_cnt_d = '0;
            seen_d     = 1'b0;
        end

        cle_activate_d = (state_d == S_CMD1) || (state_d == S_CMD2);
        ale_activate_d = (state_d == S_ADDR);
        busy_d         = (state_d != S_IDLE);

        // Byte presented from the activate cycle until its WAIT state exits
        case (state_d)
            S_CMD1:      latch_data_d = {8'h00, cmd1_d};
            S_ADDR:      latch_data_d = {8'h00, 8'(addr_q >> {idx_d, 3'b000})};
            S_CMD2:      latch_data_d = {8'h00, cmd2_q};
            S_CMD1_WAIT,
            S_ADDR_WAIT,
            S_CMD2_WAIT: latch_data_d = latch_data_q;
            default:     latch_data_d = 16'h0000;
        endcase
    end

    // State, captured request and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q        <= S_IDLE;
            cmd1_q         <= 8'h00;
            cmd2_q         <= 8'h00;
            addr_q         <= 40'h0;
            cnt_q          <= 3'd0;
            has_cmd2_q     <= 1'b0;
            idx_q          <= 3'd0;
            wait_cnt_q     <= '0;
            seen_q         <= 1'b0;
            twb_cnt_q      <= '0;
            cle_activate_q <= 1'b0;
            ale_activate_q <= 1'b0;
            latch_data_q   <= 16'h0000;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd1_q         <= cmd1_d;
            cmd2_q         <= cmd2_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            has_cmd2_q     <= has_cmd2_d;
            idx_q          <= idx_d;
            wait_cnt_q     <= wait_cnt_d;
            seen_q         <= seen_d;
            twb_cnt_q      <= twb_cnt_d;
            cle_activate_q <= cle_activate_d;
            ale_activate_q <= ale_activate_d;
            latch_data_q   <= latch_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign cle_activate = cle_activate_q;
    assign ale_activate = ale_activate_q;
    assign latch_data   = latch_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Scoreboard bench for nand_cmd_sequencer: a request-level model predicts the
// ordered activate/done/error events and their cycle spacing from the busy
// profile handed to the latch-unit model.
module tb_nand_cmd_sequencer;

    localparam int unsigned TO  = 4;
    localparam int unsigned TWB = 2;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd1 = 8'h00;
    logic [2:0]  addr_count = 3'd0;
    logic [39:0] addr = 40'h0;
    logic        has_cmd2 = 1'b0;
    logic [7:0]  cmd2 = 8'h00;
    logic        cle_busy = 1'b0;
    logic        ale_busy = 1'b0;
    logic        cle_activate;
    logic        ale_activate;
    logic [15:0] latch_data;
    logic        busy;
    logic        done;
    logic        error;

    nand_cmd_sequencer #(.BUSY_TIMEOUT(TO), .T_WB_CYCLES(TWB)) dut (
        .clk(clk), .nreset(nreset), .start(start), .cmd1(cmd1),
        .addr_count(addr_count), .addr(addr), .has_cmd2(has_cmd2), .cmd2(cmd2),
        .cle_busy(cle_busy), .ale_busy(ale_busy), .cle_activate(cle_activate),
        .ale_activate(ale_activate), .latch_data(latch_data), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // kind: 0 = CLE activate, 1 = ALE activate, 2 = done, 3 = error
    typedef struct {
        int          kind;
        logic [15:0] data;
        int          gap;
        bit          first;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    bit   mon_en = 1'b1;
    bit   noise_en = 1'b0;

    // Latch-unit busy profile per global activate number
    int   dly_arr[4096];
    int   wid_arr[4096];
    bit   stuck_arr[4096];
    int   act_count = 0;

    function automatic void check(input bit ok, input string name, input string info);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, info);
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Latch-unit model: addressed unit follows the profile, the other one chatters
    initial begin
        int  k = 1000;
        int  cur = 0;
        bit  have_owner = 1'b0;
        bit  owner_cle = 1'b0;
        bit  pulse;
        bit  noise;
        forever begin
            @(negedge clk);
            if (cle_activate || ale_activate) begin
                owner_cle  = cle_activate;
                have_owner = 1'b1;
                cur        = act_count;
                act_count  = act_count + 1;
                k          = 0;
            end else if (k < 1000) begin
                k = k + 1;
            end
            pulse = have_owner && !stuck_arr[cur] && (k >= dly_arr[cur]) &&
                    (k < dly_arr[cur] + wid_arr[cur]);
            noise = noise_en && (($urandom % 2) == 1);
            if (!have_owner) begin
                cle_busy = noise;
                ale_busy = noise;
            end else if (owner_cle) begin
                cle_busy = pulse;
                ale_busy = noise;
            end else begin
                ale_busy = pulse;
                cle_busy = noise;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event
    initial begin
        int          prev_cyc = 0;
        logic [15:0] last_data = 16'h0;
        exp_t        e;
        int          gap;
        int          kind;
        forever begin
            @(negedge clk);
            if (mon_en && nreset) begin
                if (cle_activate || ale_activate) begin
                    kind = ale_activate ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_activate",
                              $sformatf("got cle=%0b ale=%0b data=%h at cycle %0d, required none",
                                        cle_activate, ale_activate, latch_data, cyc));
                    end else begin
                        e   = exp_q.pop_front();
                        gap = e.first ? cyc - start_cyc : cyc - prev_cyc;
                        check((e.kind == kind) && !(cle_activate && ale_activate) &&
                              (latch_data == e.data) && (gap == e.gap) && busy,
                              "activate",
                              $sformatf("got kind=%0d data=%h gap=%0d busy=%0b, required kind=%0d data=%h gap=%0d busy=1",
                                        kind, latch_data, gap, busy, e.kind, e.data, e.gap));
                    end
                    prev_cyc  = cyc;
                    last_data = latch_data;
                end
                if (done || error) begin
                    kind = error ? 3 : 2;
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_end",
                              $sformatf("got done=%0b error=%0b at cycle %0d, required none",
                                        done, error, cyc));
                    end else begin
                        e   = exp_q.pop_front();
                        gap = cyc - prev_cyc;
                        check((e.kind == kind) && !(done && error) && !busy && (gap == e.gap),
                              "end_event",
                              $sformatf("got done=%0b error=%0b busy=%0b gap=%0d, required kind=%0d busy=0 gap=%0d",
                                        done, error, busy, gap, e.kind, e.gap));
                    end
                end
                check(busy ? (latch_data == 16'h0 || latch_data == last_data) : (latch_data == 16'h0),
                      "latch_hold",
                      $sformatf("got latch_data=%h busy=%0b, required 0000 or %h", latch_data, busy, last_data));
            end
        end
    end

    // Issue one request, pushing its predicted event stream first
    task automatic run_req(input logic [7:0] c1, input logic [2:0] cnt, input logic [39:0] a,
                           input bit h2, input logic [7:0] c2, input int stuck_idx,
                           input int fix_dly, input int fix_wid, input bit junk);
        logic [15:0] pd[8];
        bit          pa[8];
        int          n = 0;
        int          ncnt;
        int          base;
        int          last;
        bit          ended = 1'b0;
        bit          saw_done = 1'b0;
        exp_t        e;
        ncnt  = (cnt > 3'd5) ? 5 : int'(cnt);
        pd[n] = {8'h00, c1}; pa[n] = 1'b0; n++;
        for (int i = 0; i < ncnt; i++) begin
            pd[n] = {8'h00, a[8*i +: 8]}; pa[n] = 1'b1; n++;
        end
        if (h2) begin
            pd[n] = {8'h00, c2}; pa[n] = 1'b0; n++;
        end
        base = act_count;
        for (int i = 0; i < n; i++) begin
            dly_arr[base+i]   = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, TO));
            wid_arr[base+i]   = (fix_wid > 0) ? fix_wid : int'($urandom_range(1, 6));
            stuck_arr[base+i] = (i == stuck_idx);
        end
        last = n - 1;
        for (int i = 0; i < n; i++) begin
            if (stuck_idx >= 0 && i > stuck_idx) break;
            e.kind  = pa[i] ? 1 : 0;
            e.data  = pd[i];
            e.first = (i == 0);
            e.gap   = (i == 0) ? 1 : dly_arr[base+i-1] + wid_arr[base+i-1] + 1;
            exp_q.push_back(e);
        end
        e.data  = 16'h0;
        e.first = 1'b0;
        if (stuck_idx >= 0) begin
            e.kind = 3;
            e.gap  = TO + 1;
        end else begin
            e.kind = 2;
            e.gap  = dly_arr[base+last] + wid_arr[base+last] + 2 + (h2 ? int'(TWB) : 0);
        end
        exp_q.push_back(e);

        @(negedge clk);
        cmd1 = c1; addr_count = cnt; addr = a; has_cmd2 = h2; cmd2 = c2;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 400; w++) begin
            if (junk) begin
                cmd1 = 8'($urandom); cmd2 = 8'($urandom); addr_count = 3'($urandom);
                addr = {8'($urandom), 32'($urandom)}; has_cmd2 = 1'($urandom);
            end
            if (done || error) begin
                ended    = 1'b1;
                saw_done = done;
                break;
            end
            start = junk && (($urandom % 4) == 0);
            @(negedge clk);
        end
        if (!ended) check(1'b0, "request_end", "got no done/error within 400 cycles, required one");
        // Start held across the end of the done cycle must be ignored
        start = junk && saw_done;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check(exp_q.size() == 0, "queue_drain",
              $sformatf("got %0d pending events, required 0", exp_q.size()));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        repeat (3) @(negedge clk);
        check(!cle_activate && !ale_activate && latch_data == 16'h0 && !busy && !done && !error,
              "reset_state", $sformatf("got cle=%0b ale=%0b data=%h busy=%0b done=%0b error=%0b, required all 0",
                                       cle_activate, ale_activate, latch_data, busy, done, error));
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Read page, reset command, address clamp, timeout
        run_req(8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, -1, 1, 6, 1'b0);
        run_req(8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, -1, 2, 3, 1'b0);
        run_req(8'h90, 3'd7, 40'hEEDDCCBBAA, 1'b0, 8'h00, -1, 0, 0, 1'b0);
        run_req(8'h70, 3'd0, 40'h0, 1'b0, 8'h00, 0, 0, 0, 1'b0);
        run_req(8'h80, 3'd3, 40'h0000332211, 1'b1, 8'h10, 2, 0, 0, 1'b0);

        // Reset abandoned mid ADDR_WAIT
        mon_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dly_arr[act_count+i] = 1; wid_arr[act_count+i] = 3; stuck_arr[act_count+i] = 1'b0;
        end
        @(negedge clk);
        cmd1 = 8'h80; addr_count = 3'd5; addr = 40'h5544332211; has_cmd2 = 1'b1; cmd2 = 8'h10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hits = 0;
        for (int w = 0; w < 100 && hits < 2; w++) begin
            @(negedge clk);
            if (ale_activate) hits++;
        end
        check(hits == 2, "reach_addr_wait", $sformatf("got %0d ALE pulses, required 2", hits));
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check(!cle_activate && !ale_activate && latch_data == 16'h0 && !busy && !done && !error,
              "async_reset", $sformatf("got cle=%0b ale=%0b data=%h busy=%0b done=%0b error=%0b, required all 0",
                                       cle_activate, ale_activate, latch_data, busy, done, error));
        repeat (3) @(negedge clk);
        check(!busy && !done && !error, "reset_hold",
              $sformatf("got busy=%0b done=%0b error=%0b, required 0", busy, done, error));
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        run_req(8'h00, 3'd5, 40'h0403020100, 1'b1, 8'h30, -1, 0, 0, 1'b1);

        // Randomized traffic with busy chatter and ignored starts
        noise_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [2:0] rc;
            bit         rh;
            int         np;
            int         st;
            rc = 3'($urandom);
            rh = 1'($urandom);
            np = 1 + ((rc > 3'd5) ? 5 : int'(rc)) + (rh ? 1 : 0);
            st = (($urandom % 6) == 0) ? int'($urandom_range(0, np - 1)) : -1;
            run_req(8'($urandom), rc, {8'($urandom), 32'($urandom)}, rh, 8'($urandom),
                    st, 0, 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nand_cmd_sequencer.md
NAND_CMD_SEQUENCER -- requirements
Module: nand_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter BUSY_TIMEOUT, default 4, giving the maximum number of cycles allowed between an activate pulse and busy being seen high from the addressed latch unit.
REQ-002 The block SHALL have parameter T_WB_CYCLES, default 0, giving the number of idle cycles inserted after the second command before done is asserted.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 nreset  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 cmd1  input  8  first command byte.
REQ-007 addr_count  input  3  number of address bytes to issue, 0-5; values 6 and 7 are treated as 5.
REQ-008 addr  input  40  address bytes; byte k is addr[8k+7:8k], and byte 0 is issued first.
REQ-009 has_cmd2  input  1  when set, cmd2 is issued after the address phase.
REQ-010 cmd2  input  8  second command byte.
REQ-011 cle_busy  input  1  busy output of the command latch unit.
REQ-012 ale_busy  input  1  busy output of the address latch unit.
REQ-013 cle_activate  output  1  one-cycle activate pulse to the command latch unit.
REQ-014 ale_activate  output  1  one-cycle activate pulse to the address latch unit.
REQ-015 latch_data  output  16  data to both latch units: {8'h00, byte}.
REQ-016 busy  output  1  high in every state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on successful completion.
REQ-018 error  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 States SHALL be: IDLE, CMD1, CMD1_WAIT, ADDR, ADDR_WAIT, CMD2, CMD2_WAIT, TWB, FINISH.
REQ-020 In IDLE with start=1 at a clock edge, the block SHALL capture cmd1, the clamped addr_count, addr, has_cmd2 and cmd2, clear the byte index, and enter CMD1.
REQ-021 Inputs other than cle_busy and ale_busy SHALL be ignored outside IDLE; start outside IDLE has no effect.
REQ-022 All outputs SHALL be registered.
REQ-023 The activate pulses SHALL be high for exactly the one cycle following entry into CMD1, ADDR or CMD2.
REQ-024 latch_data SHALL hold the current byte from the activate cycle until the corresponding WAIT state exits, and SHALL be 16'h0000 otherwise.
REQ-025 Each WAIT state SHALL exit only after the addressed busy input has been observed 1 and then subsequently observed 0; a 1-to-0 transition already in progress at entry does not count.
REQ-026 If busy is not observed high within BUSY_TIMEOUT cycles after the activate cycle, the block SHALL pulse error, skip done, and return to IDLE.
REQ-027 CMD1_WAIT exit SHALL go to ADDR if addr_count>0, else to CMD2 if has_cmd2, else to FINISH.
REQ-028 ADDR_WAIT exit SHALL increment the byte index and go to ADDR if index<addr_count, else to CMD2 if has_cmd2, else to FINISH.
REQ-029 CMD2_WAIT exit SHALL go to TWB, which counts T_WB_CYCLES cycles (0 means pass straight through) and then goes to FINISH.
REQ-030 FINISH SHALL pulse done for one cycle and return to IDLE; busy deasserts in the same cycle that done is high.
REQ-031 Busy on the non-addressed latch input SHALL be ignored in every WAIT state.
REQ-032 A start pulse in the same cycle as done SHALL be ignored; a new request is accepted from the next IDLE cycle.

Reset
REQ-033 On nreset=0 the block SHALL immediately enter IDLE and drive cle_activate=0, ale_activate=0, latch_data=0, busy=0, done=0 and error=0.
REQ-034 On nreset=0 all counters and captured registers SHALL clear.
REQ-035 A reset asserted mid-sequence SHALL abandon the sequence with no done or error pulse.

Verification
REQ-036 Read page: cmd1=00, addr_count=5, addr=40'h0403020100, has_cmd2=1, cmd2=30, latch busy model 6 cycles -> one CLE pulse with 0x0000, ALE pulses with 0x00,01,02,03,04 in order, one CLE pulse with 0x0030, done once, error never.
REQ-037 Reset command: cmd1=FF, addr_count=0, has_cmd2=0 -> exactly one cle_activate, zero ale_activate, done after cle_busy falls.
REQ-038 Clamp: addr_count=7 with has_cmd2=0 -> exactly 5 ALE pulses, then done.
REQ-039 Timeout: cle_busy held 0 after activate -> error pulse 5 cycles after the activate cycle with BUSY_TIMEOUT=4, busy returns to 0, no done.
REQ-040 Reset mid-ADDR_WAIT -> all outputs 0 asynchronously; a subsequent start runs a clean full sequence.
REQ-041 start asserted during a sequence and in the done cycle -> ignored; exactly one done per accepted start.
